// File: rtl/mem_access_ctrl_if.sv
// Request/response and data_ram signal bundle for the MEM-stage load/store initiator.
// The slave side is the controller; the master side is the pipeline plus the RAM.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        stall_req;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign, stall_req,
        input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign, stall_req,
        output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: one typed request at a time becomes a single-cycle data_ram
// access with big-endian lane select, store replication and load extension.
module mem_access_ctrl (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_op;
    logic [1:0]  r_lane;
    logic        r_req_ready;
    logic        r_stall;
    logic        r_ram_ce;
    logic        r_ram_we;
    logic [31:0] r_ram_addr;
    logic [3:0]  r_ram_sel;
    logic [31:0] r_ram_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_misalign;

    logic        w_legal;
    logic        w_is_store;
    logic        w_misalign;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // Decode of the incoming request; only consumed in IDLE when it is accepted.
    always_comb begin
        w_legal    = 1'b0;
        w_is_store = 1'b0;
        w_misalign = 1'b0;
        w_sel      = 4'b0000;
        w_wdata    = 32'd0;
        case (bus.req_op)
            OP_LB, OP_LBU: begin
                w_legal = 1'b1;
                w_sel   = 4'b1000 >> bus.req_addr[1:0];
            end
            OP_SB: begin
                w_legal    = 1'b1;
                w_is_store = 1'b1;
                w_sel      = 4'b1000 >> bus.req_addr[1:0];
                w_wdata    = {4{bus.req_wdata[7:0]}};
            end
            OP_LH, OP_LHU: begin
                w_legal    = 1'b1;
                w_misalign = bus.req_addr[0];
                w_sel      = bus.req_addr[1] ? 4'b0011 : 4'b1100;
            end
            OP_SH: begin
                w_legal    = 1'b1;
                w_is_store = 1'b1;
                w_misalign = bus.req_addr[0];
                w_sel      = bus.req_addr[1] ? 4'b0011 : 4'b1100;
                w_wdata    = {2{bus.req_wdata[15:0]}};
            end
            OP_LW: begin
                w_legal    = 1'b1;
                w_misalign = (bus.req_addr[1:0] != 2'b00);
                w_sel      = 4'b1111;
            end
            OP_SW: begin
                w_legal    = 1'b1;
                w_is_store = 1'b1;
                w_misalign = (bus.req_addr[1:0] != 2'b00);
                w_sel      = 4'b1111;
                w_wdata    = bus.req_wdata;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Lane extraction of the word returned by data_ram, using the latched op and offset.
    always_comb begin
        w_byte      = 8'd0;
        w_half      = 16'd0;
        w_load_data = 32'd0;
        case (r_lane)
            2'b00:   w_byte = bus.ram_rdata[31:24];
            2'b01:   w_byte = bus.ram_rdata[23:16];
            2'b10:   w_byte = bus.ram_rdata[15:8];
            default: w_byte = bus.ram_rdata[7:0];
        endcase
        w_half = r_lane[1] ? bus.ram_rdata[15:0] : bus.ram_rdata[31:16];
        case (r_op)
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'd0, w_byte};
            OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_data = {16'd0, w_half};
            OP_LW:   w_load_data = bus.ram_rdata;
            default: w_load_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_op            <= 4'd0;
            r_lane          <= 2'd0;
            r_req_ready     <= 1'b1;
            r_stall         <= 1'b0;
            r_ram_ce        <= 1'b0;
            r_ram_we        <= 1'b0;
            r_ram_addr      <= 32'd0;
            r_ram_sel       <= 4'd0;
            r_ram_wdata     <= 32'd0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= 32'd0;
            r_resp_misalign <= 1'b0;
        end else begin
            r_ram_ce        <= 1'b0;
            r_ram_we        <= 1'b0;
            r_ram_addr      <= 32'd0;
            r_ram_sel       <= 4'd0;
            r_ram_wdata     <= 32'd0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= 32'd0;
            r_resp_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_op        <= bus.req_op;
                        r_lane      <= bus.req_addr[1:0];
                        r_req_ready <= 1'b0;
                        r_stall     <= 1'b1;
                        // Misaligned and no-op requests answer at once without touching RAM.
                        if (w_legal && !w_misalign) begin
                            r_state     <= ACCESS;
                            r_ram_ce    <= 1'b1;
                            r_ram_we    <= w_is_store;
                            r_ram_addr  <= {bus.req_addr[31:2], 2'b00};
                            r_ram_sel   <= w_sel;
                            r_ram_wdata <= w_wdata;
                        end else begin
                            r_state         <= RESP;
                            r_resp_valid    <= 1'b1;
                            r_resp_misalign <= w_misalign;
                        end
                    end
                end
                ACCESS: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_stall     <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_stall     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.stall_req     = r_stall;
    assign bus.ram_ce        = r_ram_ce;
    assign bus.ram_we        = r_ram_we;
    assign bus.ram_addr      = r_ram_addr;
    assign bus.ram_sel       = r_ram_sel;
    assign bus.ram_wdata     = r_ram_wdata;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_rdata    = r_resp_rdata;
    assign bus.resp_misalign = r_resp_misalign;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural data_ram model.
module tb_mem_access_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
    } respT;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          cyc;
    } accT;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    respT respQ[$];
    accT  accQ[$];

    logic [31:0] mem [0:63];

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // data_ram model: combinational read, lane-masked write on the rising edge
    assign bus.ram_rdata = mem[bus.ram_addr[7:2]];

    always @(posedge clk) begin
        if (bus.ram_ce && bus.ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (bus.ram_sel[l]) mem[bus.ram_addr[7:2]][l*8 +: 8] <= bus.ram_wdata[l*8 +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Response and RAM-access monitors pop the scoreboard whenever the DUT presents activity
    always @(negedge clk) begin
        if (!rst) begin
            respT r;
            accT  a;
            checkOutput("stall_is_not_ready", {31'd0, bus.stall_req}, {31'd0, ~bus.req_ready});
            if (bus.resp_valid) begin
                if (respQ.size() == 0) begin
                    checkOutput("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    r = respQ.pop_front();
                    checkOutput("resp_rdata", bus.resp_rdata, r.rdata);
                    checkOutput("resp_misalign", {31'd0, bus.resp_misalign}, {31'd0, r.mis});
                    checkOutput("resp_cycle", cyc, r.cyc);
                end
            end
            if (bus.ram_ce) begin
                if (accQ.size() == 0) begin
                    checkOutput("unexpected_ram_ce", 32'd1, 32'd0);
                end else begin
                    a = accQ.pop_front();
                    checkOutput("ram_we", {31'd0, bus.ram_we}, {31'd0, a.we});
                    checkOutput("ram_addr", bus.ram_addr, a.addr);
                    checkOutput("ram_sel", {28'd0, bus.ram_sel}, {28'd0, a.sel});
                    checkOutput("ram_wdata", bus.ram_wdata, a.wdata);
                    checkOutput("ram_cycle", cyc, a.cyc);
                end
            end else begin
                checkOutput("ram_we_without_ce", {31'd0, bus.ram_we}, 32'd0);
            end
        end
    end

    // Drives one request (called at a negedge), waits for req_ready, pushes expectations.
    task automatic applyStimulus(
        input  logic [3:0]  op,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] expRdata,
        input  logic        expMis,
        input  logic        expAcc,
        input  logic        expWe,
        input  logic [31:0] expAddr,
        input  logic [3:0]  expSel,
        input  logic [31:0] expWdata,
        output int          acceptCyc
    );
        int   waitCnt;
        respT r;
        accT  a;
        waitCnt       = 0;
        acceptCyc     = -1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        while (!bus.req_ready) begin
            @(negedge clk);
            waitCnt++;
            if (waitCnt > 20) begin
                checkOutput("req_ready_timeout", 32'd0, 32'd1);
                return;
            end
        end
        acceptCyc = cyc + 1;
        r.rdata   = expRdata;
        r.mis     = expMis;
        r.cyc     = expAcc ? acceptCyc + 1 : acceptCyc;
        respQ.push_back(r);
        if (expAcc) begin
            a.we    = expWe;
            a.addr  = expAddr;
            a.sel   = expSel;
            a.wdata = expWdata;
            a.cyc   = acceptCyc;
            accQ.push_back(a);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        repeat (n) @(negedge clk);
    endtask

    int acc0;
    int acc1;

    initial begin
        checks        = 0;
        failures      = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0BAD0000 | i;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        rst           = 1'b1;
        #12;
        checkOutput("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        checkOutput("reset_stall", {31'd0, bus.stall_req}, 32'd0);
        checkOutput("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("reset_resp_rdata", bus.resp_rdata, 32'd0);
        checkOutput("reset_ram_ce", {31'd0, bus.ram_ce}, 32'd0);
        checkOutput("reset_ram_we", {31'd0, bus.ram_we}, 32'd0);
        checkOutput("reset_ram_sel", {28'd0, bus.ram_sel}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(4'd8, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, acc0);
        idle(2);
        applyStimulus(4'd5, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, acc0);
        idle(2);

        applyStimulus(4'd6, 32'h21, 32'h80, 32'h0, 1'b0, 1'b1, 1'b1, 32'h20, 4'b0100, 32'h80808080, acc0);
        idle(2);
        applyStimulus(4'd1, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1, 1'b0, 32'h20, 4'b0100, 32'h0, acc0);
        idle(2);
        applyStimulus(4'd2, 32'h21, 32'h0, 32'h00000080, 1'b0, 1'b1, 1'b0, 32'h20, 4'b0100, 32'h0, acc0);
        idle(2);

        applyStimulus(4'd7, 32'h32, 32'h8001, 32'h0, 1'b0, 1'b1, 1'b1, 32'h30, 4'b0011, 32'h80018001, acc0);
        idle(2);
        applyStimulus(4'd3, 32'h32, 32'h0, 32'hFFFF8001, 1'b0, 1'b1, 1'b0, 32'h30, 4'b0011, 32'h0, acc0);
        idle(2);
        applyStimulus(4'd4, 32'h32, 32'h0, 32'h00008001, 1'b0, 1'b1, 1'b0, 32'h30, 4'b0011, 32'h0, acc0);
        idle(2);
        applyStimulus(4'd3, 32'h30, 32'h0, 32'h00000BAD, 1'b0, 1'b1, 1'b0, 32'h30, 4'b1100, 32'h0, acc0);
        idle(2);
        applyStimulus(4'd1, 32'h30, 32'h0, 32'h0000000B, 1'b0, 1'b1, 1'b0, 32'h30, 4'b1000, 32'h0, acc0);
        idle(2);
        applyStimulus(4'd2, 32'h33, 32'h0, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h30, 4'b0001, 32'h0, acc0);
        idle(2);

        applyStimulus(4'd5, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0, 32'h0, acc0);
        idle(2);
        applyStimulus(4'd7, 32'h05, 32'hFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0, 32'h0, acc0);
        idle(2);
        applyStimulus(4'd4, 32'h31, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0, 32'h0, acc0);
        idle(2);

        checkOutput("rst_test_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd8;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #2;
        checkOutput("rst_pre_ram_we", {31'd0, bus.ram_we}, 32'd1);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_ram_we", {31'd0, bus.ram_we}, 32'd0);
        checkOutput("rst_async_ram_ce", {31'd0, bus.ram_ce}, 32'd0);
        checkOutput("rst_async_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        applyStimulus(4'd5, 32'h40, 32'h0, 32'h0BAD0010, 1'b0, 1'b1, 1'b0, 32'h40, 4'b1111, 32'h0, acc0);
        idle(2);

        applyStimulus(4'd5, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, acc0);
        applyStimulus(4'd2, 32'h23, 32'h0, 32'h00000008, 1'b0, 1'b1, 1'b0, 32'h20, 4'b0001, 32'h0, acc1);
        checkOutput("b2b_interval_1", acc1 - acc0, 32'd3);
        applyStimulus(4'd4, 32'h20, 32'h0, 32'h00000B80, 1'b0, 1'b1, 1'b0, 32'h20, 4'b1100, 32'h0, acc0);
        checkOutput("b2b_interval_2", acc0 - acc1, 32'd3);
        applyStimulus(4'd8, 32'h44, 32'h12345678, 32'h0, 1'b0, 1'b1, 1'b1, 32'h44, 4'b1111, 32'h12345678, acc1);
        checkOutput("b2b_interval_3", acc1 - acc0, 32'd3);
        applyStimulus(4'hF, 32'h48, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0, 32'h0, acc0);
        checkOutput("b2b_interval_noop", acc0 - acc1, 32'd3);
        idle(3);
        applyStimulus(4'd5, 32'h44, 32'h0, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h44, 4'b1111, 32'h0, acc0);
        idle(5);

        checkOutput("resp_queue_drained", respQ.size(), 32'd0);
        checkOutput("access_queue_drained", accQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
